mem_arbiter: RTL and testbench

- Shares the core's single memory port between the instruction fetch unit (read-only) and the load/store path (read/write).
- Accepts one request at a time from either master and forwards it to the memory port.
- Routes the memory response back to the master that issued the request.
- Single outstanding transaction; round-robin tie-break; watchdog converts a hung memory into an error response.

---
 rtl/mem_arbiter_if.sv | 69 ++++++
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//
// Bundles every handshake/bus signal around the memory arbiter:
//   ifu_*  : instruction fetch unit request/response channel (read-only)
//   lsu_*  : load/store unit request/response channel (read/write)
//   mem_*  : the single shared memory port
//
// Modports:
//   slave  : the arbiter's view (serves IFU/LSU, drives the memory port)
//   master : the environment's view (IFU, LSU and memory model)
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    // IFU channel
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic              ifu_resp_ready;
    logic [DATA_W-1:0] ifu_rdata;
    logic              ifu_resp_err;

    // LSU channel
    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_wdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              lsu_resp_valid;
    logic              lsu_resp_ready;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_resp_err;

    // Memory port
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_resp_valid;
    logic              mem_resp_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp_err;

    modport slave (
        input  ifu_req_valid, ifu_addr, ifu_resp_ready,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready
    );

    modport master (
        output ifu_req_valid, ifu_addr, ifu_resp_ready,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory port between the IFU (read-only) and the LSU
// (read/write). One transaction is outstanding at a time; simultaneous
// requests alternate (round-robin on the last grant). A watchdog turns a
// memory that never accepts or never answers into an error response.
//
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : mem_arbiter_if.slave -- IFU, LSU and memory handshakes
//
// Parameters:
//   ADDR_W, DATA_W : address / data width (must match the interface)
//   TIMEOUT        : cycles allowed in REQ+RESP before the error response
//                    (1..255, counted by an 8-bit counter)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int         MASK_W       = DATA_W / 8;
    // The counter is compared one step early so the move to ERR happens
    // exactly TIMEOUT cycles after REQ is entered.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;
    typedef enum logic       {IFU, LSU}             master_t;

    state_t            state, state_next;
    master_t           owner, last_grant, winner;
    logic              grant;
    logic              owner_resp_ready;
    logic              timeout_hit;
    logic [7:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;

    // Arbitration: only in IDLE and never while reset is asserted, so a
    // master is not told "accepted" for a request that reset throws away.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first;
        // a path that leaves one unassigned infers a latch.
        grant  = 1'b0;
        winner = IFU;
        if (state == IDLE && !rst) begin
            if (bus.ifu_req_valid && bus.lsu_req_valid) begin
                grant  = 1'b1;
                winner = (last_grant == IFU) ? LSU : IFU;
            end else if (bus.lsu_req_valid) begin
                grant  = 1'b1;
                winner = LSU;
            end else if (bus.ifu_req_valid) begin
                grant  = 1'b1;
                winner = IFU;
            end
        end
    end

    assign owner_resp_ready = (owner == LSU) ? bus.lsu_resp_ready : bus.ifu_resp_ready;
    assign timeout_hit      = (cnt == TIMEOUT_LAST);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: registers are written with non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic. A completed response handshake wins over a timeout
    // landing in the same cycle; otherwise the watchdog wins.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant) state_next = REQ;
            REQ: begin
                if (timeout_hit)            state_next = ERR;
                else if (bus.mem_req_ready) state_next = RESP;
            end
            RESP: begin
                if (bus.mem_resp_valid && owner_resp_ready) state_next = IDLE;
                else if (timeout_hit)                       state_next = ERR;
            end
            ERR: if (owner_resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant bookkeeping, registered request fields and watchdog counter.
    // The mem_* fields are reset too, since all outputs read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= IFU;
            last_grant <= IFU;
            cnt        <= '0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else if (grant) begin
            owner      <= winner;
            last_grant <= winner;
            cnt        <= '0;
            if (winner == LSU) begin
                addr_q  <= bus.lsu_addr;
                wen_q   <= bus.lsu_wen;
                wdata_q <= bus.lsu_wdata;
                wmask_q <= bus.lsu_wmask;
            end else begin
                addr_q  <= bus.ifu_addr;
                wen_q   <= 1'b0;
                wdata_q <= '0;
                wmask_q <= '0;
            end
        end else if (state == REQ || state == RESP) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Output logic: memory response is routed to the owner only; the other
    // master sees an idle, zeroed response channel.
    always_comb begin
        bus.ifu_req_ready  = grant && (winner == IFU);
        bus.lsu_req_ready  = grant && (winner == LSU);
        bus.mem_req_valid  = (state == REQ);
        bus.mem_resp_ready = (state == RESP) && owner_resp_ready;
        bus.ifu_resp_valid = 1'b0;
        bus.ifu_rdata      = '0;
        bus.ifu_resp_err   = 1'b0;
        bus.lsu_resp_valid = 1'b0;
        bus.lsu_rdata      = '0;
        bus.lsu_resp_err   = 1'b0;
        case (state)
            RESP: begin
                if (owner == LSU) begin
                    bus.lsu_resp_valid = bus.mem_resp_valid;
                    bus.lsu_rdata      = bus.mem_rdata;
                    bus.lsu_resp_err   = bus.mem_resp_err;
                end else begin
                    bus.ifu_resp_valid = bus.mem_resp_valid;
                    bus.ifu_rdata      = bus.mem_rdata;
                    bus.ifu_resp_err   = bus.mem_resp_err;
                end
            end
            ERR: begin
                // Any late memory response is ignored here (mem_resp_ready=0).
                if (owner == LSU) begin
                    bus.lsu_resp_valid = 1'b1;
                    bus.lsu_resp_err   = 1'b1;
                end else begin
                    bus.ifu_resp_valid = 1'b1;
                    bus.ifu_resp_err   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wen   = wen_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wmask = wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A transaction-level reference model
// (who may be granted, which request is in flight, whether it is waiting for
// the memory to take it or to answer it) predicts every DUT output each
// cycle. Directed steps cover reset, single fetch, tie alternation, memory
// back-pressure, response back-pressure, reset mid-transaction; a second
// instance with TIMEOUT=4 covers the watchdog; a randomized phase follows.
// Inputs are driven 1 time unit after the rising edge, outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_to ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst), .bus(bus_to)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase of the single outstanding transaction.
    typedef enum int {P_IDLE, P_REQ, P_RESP} phase_t;
    phase_t      m_phase    = P_IDLE;
    logic        m_owner_lsu = 1'b0;
    logic        m_last_lsu  = 1'b0;
    int          last_win    = 0;
    logic [31:0] c_addr, c_wdata;
    logic        c_wen;
    logic [3:0]  c_mask;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // 0 = nobody, 1 = IFU, 2 = LSU. Ties go to whoever was not granted last.
    function automatic int pick();
        if (rst || m_phase != P_IDLE) return 0;
        if (bus.ifu_req_valid && bus.lsu_req_valid) return m_last_lsu ? 1 : 2;
        if (bus.lsu_req_valid) return 2;
        if (bus.ifu_req_valid) return 1;
        return 0;
    endfunction

    task automatic sample();
        int   w;
        logic own_rdy, in_resp, ifu_own, lsu_own;
        @(negedge clk);
        w       = pick();
        own_rdy = m_owner_lsu ? bus.lsu_resp_ready : bus.ifu_resp_ready;
        in_resp = (m_phase == P_RESP);
        ifu_own = in_resp && !m_owner_lsu;
        lsu_own = in_resp && m_owner_lsu;
        check("ifu_req_ready", bus.ifu_req_ready, w == 1);
        check("lsu_req_ready", bus.lsu_req_ready, w == 2);
        check("mem_req_valid", bus.mem_req_valid, m_phase == P_REQ);
        check("mem_resp_ready", bus.mem_resp_ready, in_resp && own_rdy);
        check("ifu_resp_valid", bus.ifu_resp_valid, ifu_own && bus.mem_resp_valid);
        check("ifu_rdata", bus.ifu_rdata, ifu_own ? bus.mem_rdata : 32'h0);
        check("ifu_resp_err", bus.ifu_resp_err, ifu_own && bus.mem_resp_err);
        check("lsu_resp_valid", bus.lsu_resp_valid, lsu_own && bus.mem_resp_valid);
        check("lsu_rdata", bus.lsu_rdata, lsu_own ? bus.mem_rdata : 32'h0);
        check("lsu_resp_err", bus.lsu_resp_err, lsu_own && bus.mem_resp_err);
        if (m_phase == P_REQ) begin
            check("mem_addr", bus.mem_addr, c_addr);
            check("mem_wen", bus.mem_wen, c_wen);
            check("mem_wdata", bus.mem_wdata, c_wdata);
            check("mem_wmask", bus.mem_wmask, c_mask);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        last_win = 0;
        if (rst) begin
            m_phase    = P_IDLE;
            m_last_lsu = 1'b0;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    last_win = pick();
                    if (last_win != 0) begin
                        m_owner_lsu = (last_win == 2);
                        m_last_lsu  = m_owner_lsu;
                        if (m_owner_lsu) begin
                            c_addr = bus.lsu_addr;  c_wen  = bus.lsu_wen;
                            c_wdata = bus.lsu_wdata; c_mask = bus.lsu_wmask;
                        end else begin
                            c_addr = bus.ifu_addr;  c_wen  = 1'b0;
                            c_wdata = 32'h0;        c_mask = 4'h0;
                        end
                        m_phase = P_REQ;
                    end
                end
                P_REQ:  if (bus.mem_req_ready) m_phase = P_RESP;
                P_RESP: if (bus.mem_resp_valid &&
                            (m_owner_lsu ? bus.lsu_resp_ready : bus.ifu_resp_ready))
                            m_phase = P_IDLE;
                default: m_phase = P_IDLE;
            endcase
        end
        #1;
    endtask

    task automatic clear_inputs();
        bus.ifu_req_valid = 0; bus.ifu_addr = 0; bus.ifu_resp_ready = 0;
        bus.lsu_req_valid = 0; bus.lsu_addr = 0; bus.lsu_wen = 0;
        bus.lsu_wdata = 0; bus.lsu_wmask = 0; bus.lsu_resp_ready = 0;
        bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = 0; bus.mem_resp_err = 0;
        bus_to.ifu_req_valid = 0; bus_to.ifu_addr = 0; bus_to.ifu_resp_ready = 0;
        bus_to.lsu_req_valid = 0; bus_to.lsu_addr = 0; bus_to.lsu_wen = 0;
        bus_to.lsu_wdata = 0; bus_to.lsu_wmask = 0; bus_to.lsu_resp_ready = 0;
        bus_to.mem_req_ready = 0; bus_to.mem_resp_valid = 0;
        bus_to.mem_rdata = 0; bus_to.mem_resp_err = 0;
    endtask

    // Random masters and memory. The memory holds a response stable until
    // the handshake and only answers while a request is outstanding.
    task automatic drive_random();
        rst = ($urandom_range(0, 299) == 0);
        if (bus.ifu_req_valid)
            bus.ifu_req_valid = (last_win == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
        else if ($urandom_range(0, 2) == 0) begin
            bus.ifu_req_valid = 1; bus.ifu_addr = $urandom;
        end
        if (bus.lsu_req_valid)
            bus.lsu_req_valid = (last_win == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
        else if ($urandom_range(0, 2) == 0) begin
            bus.lsu_req_valid = 1;          bus.lsu_addr  = $urandom;
            bus.lsu_wen = 1'($urandom);     bus.lsu_wdata = $urandom;
            bus.lsu_wmask = 4'($urandom);
        end
        bus.ifu_resp_ready = ($urandom_range(0, 3) != 0);
        bus.lsu_resp_ready = ($urandom_range(0, 3) != 0);
        bus.mem_req_ready  = 1'($urandom);
        if (m_phase == P_RESP) begin
            if (!bus.mem_resp_valid && $urandom_range(0, 1) == 0) begin
                bus.mem_resp_valid = 1;
                bus.mem_rdata      = $urandom;
                bus.mem_resp_err   = ($urandom_range(0, 7) == 0);
            end
        end else begin
            bus.mem_resp_valid = 0; bus.mem_rdata = 0; bus.mem_resp_err = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        clear_inputs();
        rst = 1;
        advance();
        advance();
        rst = 0;

        // Reset state: every output 0.
        sample();
        check("t0_mem_addr", bus.mem_addr, 32'h0);
        check("t0_mem_wdata", bus.mem_wdata, 32'h0);
        check("t0_mem_wmask", bus.mem_wmask, 4'h0);
        check("t0_mem_wen", bus.mem_wen, 1'b0);
        check("t0_to_req_valid", bus_to.mem_req_valid, 1'b0);
        advance();

        // T1: IFU-only fetch, zero-wait memory.
        bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0000; bus.ifu_resp_ready = 1;
        sample();
        check("t1_grant_c0", bus.ifu_req_ready, 1'b1);
        advance();
        bus.ifu_req_valid = 0; bus.mem_req_ready = 1;
        sample();
        check("t1_req_valid_c1", bus.mem_req_valid, 1'b1);
        check("t1_wen_c1", bus.mem_wen, 1'b0);
        check("t1_addr_c1", bus.mem_addr, 32'h8000_0000);
        advance();
        bus.mem_req_ready = 0; bus.mem_resp_valid = 1; bus.mem_rdata = 32'h0000_0413;
        sample();
        check("t1_resp_valid_c2", bus.ifu_resp_valid, 1'b1);
        check("t1_rdata_c2", bus.ifu_rdata, 32'h0000_0413);
        advance();
        bus.mem_resp_valid = 0; bus.mem_rdata = 0;
        sample();
        check("t1_idle_req_valid_c3", bus.mem_req_valid, 1'b0);
        check("t1_idle_resp_valid_c3", bus.ifu_resp_valid, 1'b0);
        advance();
        clear_inputs();

        // T2: permanent tie right after reset -> LSU, IFU, LSU, IFU.
        rst = 1;
        advance();
        rst = 0;
        bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0100; bus.ifu_resp_ready = 1;
        bus.lsu_req_valid = 1; bus.lsu_addr = 32'h8000_2000; bus.lsu_resp_ready = 1;
        for (int k = 0; k < 4; k++) begin
            logic exp_lsu;
            exp_lsu = (k % 2 == 0);
            sample();
            check("t2_lsu_grant", bus.lsu_req_ready, exp_lsu);
            check("t2_ifu_grant", bus.ifu_req_ready, !exp_lsu);
            advance();
            bus.mem_req_ready = 1;
            sample();
            advance();
            bus.mem_req_ready = 0; bus.mem_resp_valid = 1; bus.mem_rdata = $urandom;
            sample();
            advance();
            bus.mem_resp_valid = 0; bus.mem_rdata = 0;
        end
        clear_inputs();

        // T3: LSU store with memory stalling the request 3 cycles.
        bus.lsu_req_valid = 1; bus.lsu_addr = 32'h8000_1000; bus.lsu_wen = 1;
        bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_wmask = 4'hF;
        bus.lsu_resp_ready = 1; bus.ifu_resp_ready = 1;
        sample();
        check("t3_grant", bus.lsu_req_ready, 1'b1);
        advance();
        bus.lsu_req_valid = 0; bus.lsu_wdata = 0; bus.lsu_addr = 0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_req_ready = (i == 3);
            sample();
            check("t3_req_valid", bus.mem_req_valid, 1'b1);
            check("t3_addr", bus.mem_addr, 32'h8000_1000);
            check("t3_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            check("t3_wmask", bus.mem_wmask, 4'hF);
            check("t3_wen", bus.mem_wen, 1'b1);
            advance();
        end
        bus.mem_req_ready = 0;
        sample();
        check("t3_no_early_resp", bus.lsu_resp_valid, 1'b0);
        advance();
        bus.mem_resp_valid = 1;
        sample();
        check("t3_resp_valid", bus.lsu_resp_valid, 1'b1);
        check("t3_ifu_quiet", bus.ifu_resp_valid, 1'b0);
        advance();
        clear_inputs();

        // T4: owner back-pressures the response for 5 cycles.
        bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0040;
        sample();
        advance();
        bus.ifu_req_valid = 0; bus.mem_req_ready = 1;
        sample();
        advance();
        bus.mem_req_ready = 0; bus.mem_resp_valid = 1; bus.mem_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 6; i++) begin
            bus.ifu_resp_ready = (i == 5);
            sample();
            check("t4_mem_resp_ready", bus.mem_resp_ready, i == 5);
            check("t4_resp_valid", bus.ifu_resp_valid, 1'b1);
            check("t4_rdata", bus.ifu_rdata, 32'hCAFE_F00D);
            advance();
        end
        bus.mem_resp_valid = 0; bus.mem_rdata = 0;
        sample();
        check("t4_done_valid", bus.ifu_resp_valid, 1'b0);
        check("t4_done_ready", bus.mem_resp_ready, 1'b0);
        advance();
        clear_inputs();

        // T5: TIMEOUT=4 instance, memory never takes the request.
        bus_to.ifu_req_valid = 1; bus_to.ifu_addr = 32'h8000_0080;
        sample();
        check("t5_grant", bus_to.ifu_req_ready, 1'b1);
        advance();
        bus_to.ifu_req_valid = 0;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("t5_req_valid", bus_to.mem_req_valid, 1'b1);
            advance();
        end
        bus_to.mem_resp_valid = 1; bus_to.mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            bus_to.ifu_resp_ready = (i == 1);
            sample();
            check("t5_err_req_valid", bus_to.mem_req_valid, 1'b0);
            check("t5_err_resp_ready", bus_to.mem_resp_ready, 1'b0);
            check("t5_err_valid", bus_to.ifu_resp_valid, 1'b1);
            check("t5_err_flag", bus_to.ifu_resp_err, 1'b1);
            check("t5_err_rdata", bus_to.ifu_rdata, 32'h0);
            advance();
        end
        bus_to.mem_resp_valid = 0; bus_to.mem_rdata = 0; bus_to.ifu_resp_ready = 0;
        bus_to.lsu_req_valid = 1; bus_to.lsu_addr = 32'h8000_3000;
        sample();
        check("t5_new_grant", bus_to.lsu_req_ready, 1'b1);
        check("t5_after_err_valid", bus_to.ifu_resp_valid, 1'b0);
        advance();
        clear_inputs();

        // T6: reset while the LSU owns a pending response.
        bus.lsu_req_valid = 1; bus.lsu_addr = 32'h8000_4000;
        sample();
        advance();
        bus.lsu_req_valid = 0; bus.mem_req_ready = 1;
        sample();
        advance();
        bus.mem_req_ready = 0; bus.mem_resp_valid = 1; bus.mem_rdata = 32'h5555_AAAA;
        rst = 1;
        sample();
        check("t6_in_resp", bus.lsu_resp_valid, 1'b1);
        advance();
        rst = 0;
        clear_inputs();
        sample();
        check("t6_req_valid", bus.mem_req_valid, 1'b0);
        check("t6_resp_ready", bus.mem_resp_ready, 1'b0);
        check("t6_lsu_valid", bus.lsu_resp_valid, 1'b0);
        check("t6_lsu_rdata", bus.lsu_rdata, 32'h0);
        check("t6_mem_addr", bus.mem_addr, 32'h0);
        check("t6_mem_wen", bus.mem_wen, 1'b0);
        advance();
        bus.ifu_req_valid = 1; bus.lsu_req_valid = 1;
        sample();
        check("t6_tie_lsu", bus.lsu_req_ready, 1'b1);
        check("t6_tie_ifu", bus.ifu_req_ready, 1'b0);
        advance();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            sample();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
